// File: rtl/run_detect_arbiter_if.sv
// Request/result bundle for run_detect_arbiter: N_REQ frame producers in, one per-frame result out.
interface run_detect_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic                    res_hit;
  logic [CNT_W-1:0]        res_count;
  logic                    busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_hit, res_count, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_hit, res_count, busy
  );
endinterface

// File: rtl/run_detect_arbiter.sv
// Round-robin shared serial run detector (RUN_DETECT_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins).
// Latency: accept at t -> res_valid at t+DATA_W+1; frame period >= DATA_W+2.
// Backpressure: result held in REPORT until res_ready; no req_ready outside IDLE.
module run_detect_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  run_detect_arbiter_if.slave bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int RUN_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   res_id_q;
  logic [ID_W-1:0]   win_idx;
  logic              win_vld;
  logic [DATA_W-1:0] shreg;
  logic              last_bit;
  logic [RUN_W-1:0]  run_q, run_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic              last_shift;

  // Scan downward so the candidate closest to the start pointer is written last.
  always_comb begin
    int start;
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
`ifdef RUN_DETECT_ARB_FIXED_PRIO_EN
    start   = 0;
`else
    start   = int'(rr_ptr);
`endif
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && win_vld) bus.req_ready = N_REQ'(1) << win_idx;
  end

  assign last_shift    = (bit_cnt == BIT_W'(DATA_W - 1));
  assign bus.res_valid = (state_q == REPORT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_id    = res_id_q;
  assign bus.res_count = hit_cnt;
  assign bus.res_hit   = |hit_cnt;

  // A run restarts on the first bit of a frame or on any change of bit value.
  always_comb begin
    if (bit_cnt == '0 || shreg[0] != last_bit) run_nxt = RUN_W'(1);
    else if (run_q == RUN_W'(RUN_LEN))         run_nxt = run_q;
    else                                        run_nxt = run_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = REPORT;
      REPORT:  if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      res_id_q <= '0;
      shreg    <= '0;
      last_bit <= 1'b0;
      run_q    <= '0;
      bit_cnt  <= '0;
      hit_cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            shreg    <= bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
            res_id_q <= win_idx;
            last_bit <= 1'b0;
            run_q    <= '0;
            bit_cnt  <= '0;
            hit_cnt  <= '0;
          end
        end
        SHIFT: begin
          shreg    <= shreg >> 1;
          last_bit <= shreg[0];
          run_q    <= run_nxt;
          bit_cnt  <= bit_cnt + 1'b1;
          if (run_nxt == RUN_W'(RUN_LEN) && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end
        REPORT: begin
          if (bus.res_ready) begin
`ifdef RUN_DETECT_ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`else
            rr_ptr <= (int'(res_id_q) == N_REQ - 1) ? '0 : res_id_q + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_run_detect_arbiter.sv
// Randomized and directed bench for run_detect_arbiter against a frame-level reference model.
module tb_run_detect_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int RL = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  int   rr = 0;
  int   cyc = 0;
  int   last_grant = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  run_detect_arbiter_if #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) bus ();
  run_detect_arbiter_if #(.N_REQ(N), .DATA_W(DW), .CNT_W(2))  bus2 ();

  run_detect_arbiter #(.N_REQ(N), .DATA_W(DW), .RUN_LEN(RL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  run_detect_arbiter #(.N_REQ(N), .DATA_W(DW), .RUN_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hits = bit positions whose trailing run of equal bits within the frame is >= rl.
  function automatic int model_hits(input logic [7:0] d, input int rl, input int maxc);
    int hits = 0;
    for (int i = 0; i < DW; i++) begin
      int len = 1;
      for (int j = i - 1; j >= 0; j--) begin
        if (d[j] != d[i]) break;
        len++;
      end
      if (len >= rl) hits++;
    end
    return (hits > maxc) ? maxc : hits;
  endfunction

  function automatic int model_win(input logic [3:0] v);
    int start;
`ifdef RUN_DETECT_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic txn(input logic [3:0] vmask, input logic [31:0] data, input int stall,
                     input bit hold, input int exp_gap);
    int w, hc, n;
    bit bad, bad2;
    bus.req_valid = vmask;
    bus.req_data  = data;
    bus.res_ready = (stall == 0);
    #1;
    w  = model_win(vmask);
    hc = model_hits(data[w*DW +: DW], RL, 255);
    check("grant", 32'(bus.req_ready), 32'(1) << w);
    check("idle_busy", 32'(bus.busy), 0);
    if (exp_gap > 0 && last_grant >= 0) check("grant_gap", cyc - last_grant, exp_gap);
    last_grant = cyc;
    step();
    n = 1;
    bad = 1'b0;
    if (!hold) bus.req_valid = '0;
    bus.req_data = $urandom;
    while (!bus.res_valid && n < 40) begin
      if (bus.req_ready != '0 || !bus.busy) bad = 1'b1;
      step();
      n++;
    end
    check("latency", n, DW + 1);
    check("no_ready_in_shift", 32'(bad), 0);
    check("res_id", 32'(bus.res_id), w);
    check("res_count", 32'(bus.res_count), hc);
    check("res_hit", 32'(bus.res_hit), (hc != 0) ? 1 : 0);
    bad2 = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      if (!bus.res_valid || bus.res_id != w[1:0] || int'(bus.res_count) != hc || bus.req_ready != '0)
        bad2 = 1'b1;
    end
    if (stall > 0) check("stall_hold", 32'(bad2), 0);
    bus.res_ready = 1'b1;
    step();
    check("res_drop", 32'(bus.res_valid), 0);
`ifndef RUN_DETECT_ARB_FIXED_PRIO_EN
    rr = (w + 1) % N;
`endif
  endtask

  task automatic txn2(input logic [7:0] d);
    int n;
    bus2.req_valid = 4'b0001;
    bus2.req_data  = {24'h0, d};
    bus2.res_ready = 1'b1;
    #1;
    step();
    bus2.req_valid = '0;
    n = 1;
    while (!bus2.res_valid && n < 40) begin
      step();
      n++;
    end
    check("sat_latency", n, DW + 1);
    check("sat_count", 32'(bus2.res_count), model_hits(d, 2, 3));
    check("sat_hit", 32'(bus2.res_hit), (model_hits(d, 2, 3) != 0) ? 1 : 0);
    step();
  endtask

  initial begin
    bit bad;
    reset = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.res_ready  = 1'b1;
    bus2.req_valid = '0;
    bus2.req_data  = '0;
    bus2.res_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_res_id", 32'(bus.res_id), 0);
    check("rst_res_count", 32'(bus.res_count), 0);
    check("rst_res_hit", 32'(bus.res_hit), 0);

    txn(4'b0001, 32'h0000_000F, 0, 1'b0, 0);
    txn(4'b0100, 32'h00FF_0000, 0, 1'b0, 0);
    txn(4'b0010, 32'h0000_5500, 0, 1'b0, 0);
    txn(4'b1000, 32'hC300_0000, 5, 1'b0, 0);

    // Abort a frame with reset in its 4th shift cycle.
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h00F0_0000;
    #1;
    step();
    bus.req_valid = '0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    rr = 0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_res_valid", 32'(bus.res_valid), 0);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.res_valid) bad = 1'b1;
      step();
    end
    check("abort_no_result", 32'(bad), 0);

    last_grant = -1;
    for (int i = 0; i < 5; i++) txn(4'b1111, 32'h0F33_FF81 + 32'(i), 0, 1'b1, DW + 2);
    bus.req_valid = '0;
    step();

    for (int i = 0; i < 30; i++)
      txn(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3), 1'b0, 0);

    txn2(8'h00);
    txn2(8'hAA);
    txn2(8'hF0);
    for (int i = 0; i < 3; i++) txn2(8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
